// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, bus widths and arbiter state encoding.
package sdram_pkg;

  localparam int CMD_W  = 4;
  localparam int BA_W   = 2;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: refresh-first, write/read round-robin, muxes the granted
// engine onto the SDRAM command/address/data pins.
module sdram_arbit
  import sdram_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [CMD_W-1:0]  aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq,
  output logic [DATA_W-1:0] sdram_rd_data
);

  arb_state_e state_q, state_d;
  logic       last_wr_q, last_wr_d;
  logic [CMD_W-1:0] cmd_sel;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_INIT;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)                state_d = ST_AREF;
        else if (wr_req && rd_req)   state_d = last_wr_q ? ST_READ : ST_WRITE;
        else if (wr_req)             state_d = ST_WRITE;
        else if (rd_req)             state_d = ST_READ;
      end
      ST_AREF:  if (aref_end) state_d = ST_ARBIT;
      ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
      ST_READ:  if (rd_end)   state_d = ST_ARBIT;
      default:  state_d = ST_INIT;
    endcase
  end

  // Round-robin memory only moves on a write/read grant; refresh leaves it alone.
  always_comb begin
    last_wr_d = last_wr_q;
    if (state_q == ST_ARBIT && state_d == ST_WRITE) last_wr_d = 1'b1;
    if (state_q == ST_ARBIT && state_d == ST_READ)  last_wr_d = 1'b0;
  end

  always_comb begin
    aref_en    = (state_q == ST_AREF);
    wr_en      = (state_q == ST_WRITE);
    rd_en      = (state_q == ST_READ);
    cmd_sel    = CMD_NOP;
    sdram_ba   = '0;
    sdram_addr = '0;
    case (state_q)
      ST_INIT:  begin cmd_sel = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
      ST_AREF:  begin cmd_sel = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
      ST_WRITE: begin cmd_sel = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
      ST_READ:  begin cmd_sel = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
      default:  ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
  assign sdram_cke     = 1'b1;
  assign sdram_dq      = (state_q == ST_WRITE && wr_sdram_en) ? wr_sdram_data : {DATA_W{1'bz}};
  assign sdram_rd_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed table, corner sequences and
// randomized traffic against a rule-level reference model.
module tb_sdram_arbit;

  logic        sys_clk, sys_rst_n;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data, sdram_rd_data, tb_dq_val;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;

  int checks = 0;
  int passes = 0;

  // reference model: 0 init, 1 arbit, 2 refresh, 3 write, 4 read
  int   m_state;
  logic m_last_wr;
  logic tb_dq_oe;

  assign tb_dq_oe = !(m_state == 3 && wr_sdram_en);
  assign sdram_dq = tb_dq_oe ? tb_dq_val : 16'hzzzz;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq(sdram_dq), .sdram_rd_data(sdram_rd_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Apply the arbitration rules to the inputs sampled at this edge.
  task automatic model_step();
    int nxt;
    nxt = m_state;
    case (m_state)
      0: if (init_end) nxt = 1;
      1: begin
        if (aref_req) nxt = 2;
        else if (wr_req && !(rd_req && m_last_wr)) nxt = 3;
        else if (rd_req) nxt = 4;
      end
      2: if (aref_end) nxt = 1;
      3: if (wr_end) nxt = 1;
      4: if (rd_end) nxt = 1;
      default: nxt = 0;
    endcase
    if (nxt == 3 && m_state == 1) m_last_wr = 1'b1;
    if (nxt == 4 && m_state == 1) m_last_wr = 1'b0;
    m_state = nxt;
  endtask

  task automatic check_all(input string tag);
    logic [2:0]  eg;
    logic [19:0] ep;
    eg = {m_state == 2, m_state == 3, m_state == 4};
    case (m_state)
      0:       ep = {1'b1, init_cmd, init_ba, init_addr};
      2:       ep = {1'b1, aref_cmd, aref_ba, aref_addr};
      3:       ep = {1'b1, wr_cmd, wr_ba, wr_addr};
      4:       ep = {1'b1, rd_cmd, rd_ba, rd_addr};
      default: ep = {1'b1, 4'b0111, 2'b00, 13'd0};
    endcase
    chk({tag, ".grant"}, {29'd0, aref_en, wr_en, rd_en}, {29'd0, eg});
    chk({tag, ".pins"}, {12'd0, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                         sdram_ba, sdram_addr}, {12'd0, ep});
    if (!tb_dq_oe) chk({tag, ".dq"}, {16'd0, sdram_dq}, {16'd0, wr_sdram_data});
    else           chk({tag, ".rd_data"}, {16'd0, sdram_rd_data}, {16'd0, tb_dq_val});
  endtask

  task automatic step(input string tag);
    @(posedge sys_clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic clr_ctl();
    init_end = 0; aref_req = 0; aref_end = 0;
    wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
  endtask

  typedef struct {
    logic       aref_req, wr_req, rd_req, aref_end, wr_end, rd_end;
    logic [2:0] exp_grant;
  } vec_t;

  vec_t vt[8];

  initial begin
    // all three requests together, plus an rd_end that arrives during WRITE
    vt[0] = '{1, 1, 1, 0, 0, 0, 3'b100};
    vt[1] = '{0, 1, 1, 1, 0, 0, 3'b000};
    vt[2] = '{0, 1, 1, 0, 0, 0, 3'b010};
    vt[3] = '{0, 1, 1, 0, 0, 1, 3'b010};
    vt[4] = '{0, 1, 1, 0, 1, 0, 3'b000};
    vt[5] = '{0, 1, 1, 0, 0, 0, 3'b001};
    vt[6] = '{0, 0, 0, 0, 0, 0, 3'b001};
    vt[7] = '{0, 0, 0, 0, 0, 1, 3'b000};

    clr_ctl();
    sys_rst_n = 0;
    m_state = 0; m_last_wr = 0;
    init_cmd = 4'b0111; init_ba = 2'd2; init_addr = 13'h0400;
    aref_cmd = 4'b0001; aref_ba = 2'd0; aref_addr = 13'h0;
    wr_cmd = 4'b0100; wr_ba = 2'd1; wr_addr = 13'h0123;
    rd_cmd = 4'b0101; rd_ba = 2'd3; rd_addr = 13'h1ABC;
    wr_sdram_en = 1; wr_sdram_data = 16'hA5A5; tb_dq_val = 16'h1234;
    #3;
    check_all("reset");
    #4 sys_rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      init_cmd = (i % 2 == 0) ? 4'b0111 : 4'b0010;
      step("init_wait");
    end
    init_end = 1;
    step("init_done");
    chk("arbit_after_init", {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 32'h7);
    init_end = 0;

    for (int i = 0; i < 8; i++) begin
      aref_req = vt[i].aref_req; wr_req = vt[i].wr_req; rd_req = vt[i].rd_req;
      aref_end = vt[i].aref_end; wr_end = vt[i].wr_end; rd_end = vt[i].rd_end;
      step("table");
      chk($sformatf("table[%0d]", i), {29'd0, aref_en, wr_en, rd_en}, {29'd0, vt[i].exp_grant});
    end
    clr_ctl();
    step("idle");

    // both requests held: grants must alternate W R W R
    wr_req = 1; rd_req = 1;
    for (int b = 0; b < 4; b++) begin
      int n = 0;
      while (!wr_en && !rd_en && n < 6) begin step("alt_wait"); n++; end
      chk($sformatf("alt_grant[%0d]", b), {30'd0, wr_en, rd_en}, (b % 2 == 0) ? 32'd2 : 32'd1);
      step("alt_burst");
      if (wr_en) wr_end = 1; else rd_end = 1;
      step("alt_end");
      wr_end = 0; rd_end = 0;
      chk($sformatf("alt_release[%0d]", b), {30'd0, wr_en, rd_en}, 32'd0);
    end
    clr_ctl();
    step("idle2");

    // asynchronous reset during READ
    rd_req = 1;
    step("rd_grant");
    chk("rd_en_before_rst", {31'd0, rd_en}, 32'd1);
    #2 sys_rst_n = 0;
    m_state = 0; m_last_wr = 0;
    #1;
    chk("rd_en_async_drop", {31'd0, rd_en}, 32'd0);
    check_all("mid_reset");
    #2 sys_rst_n = 1;
    for (int i = 0; i < 3; i++) step("post_rst_init");
    init_end = 1;
    step("reinit");
    init_end = 0;
    step("rd_resume");
    chk("rd_en_resume", {31'd0, rd_en}, 32'd1);
    clr_ctl();
    rd_end = 1;
    step("rd_resume_end");
    rd_end = 0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      init_end = ($urandom_range(0, 15) == 0);
      aref_req = ($urandom_range(0, 7) == 0);
      wr_req = $urandom_range(0, 1); rd_req = $urandom_range(0, 1);
      aref_end = ($urandom_range(0, 3) == 0);
      wr_end = ($urandom_range(0, 3) == 0);
      rd_end = ($urandom_range(0, 3) == 0);
      init_cmd = 4'($urandom); aref_cmd = 4'($urandom);
      wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
      init_ba = 2'($urandom); aref_ba = 2'($urandom);
      wr_ba = 2'($urandom); rd_ba = 2'($urandom);
      init_addr = 13'($urandom); aref_addr = 13'($urandom);
      wr_addr = 13'($urandom); rd_addr = 13'($urandom);
      wr_sdram_en = $urandom_range(0, 1);
      tb_dq_val = 16'($urandom) & 16'h7FFF;
      wr_sdram_data = ~tb_dq_val;
      step("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
